// File: rtl/divide_sequential.sv
// -----------------------------------------------------------------------------
// divide_sequential
// Sequential signed restoring divider. It produces one quotient bit per clock
// and writes the quotient to LO and the remainder to HI, which are the same
// special registers the multiplier feeds.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        division request, sampled only while idle
//   Ra           dividend (two's complement), sampled on the accepting edge
//   Rb           divisor  (two's complement), sampled on the accepting edge
//   HI           remainder, registered
//   LO           quotient, registered
//   busy         high while a division is in progress
//   done         one-cycle pulse, HI/LO valid
//   div_by_zero  set together with done when the divisor was zero
// -----------------------------------------------------------------------------
module divide_sequential #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        neg_val = ~v + ONE_W;
    endfunction

    // Magnitude; the most negative value maps to its unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        abs_val = v[WIDTH-1] ? neg_val(v) : v;
    endfunction

    state_t           state_r, state_s;
    logic [CW-1:0]    count_r, count_s;
    logic [WIDTH:0]   rem_r, rem_s;
    // Holds the dividend magnitude, which shifts out as quotient bits shift in.
    // On a divide by zero it holds the raw dividend for HI instead.
    logic [WIDTH-1:0] q_r, q_s;
    logic [WIDTH-1:0] div_r, div_s;
    logic             sign_q_r, sign_q_s;
    logic             sign_r_r, sign_r_s;
    logic             dbz_r, dbz_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             dbz_out_r, dbz_out_s;

    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH-1:0] q_shift_s;
    logic [WIDTH:0]   trial_s;

    // One restoring step: shift {rem, q} left and trial-subtract the divisor.
    always_comb begin
        rem_shift_s = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
        q_shift_s   = {q_r[WIDTH-2:0], 1'b0};
        trial_s     = rem_shift_s - {1'b0, div_r};
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        rem_s     = rem_r;
        q_s       = q_r;
        div_s     = div_r;
        sign_q_s  = sign_q_r;
        sign_r_s  = sign_r_r;
        dbz_s     = dbz_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        done_s    = 1'b0;
        dbz_out_s = dbz_out_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (Rb != ZERO_W) begin
                        q_s      = abs_val(Ra);
                        div_s    = abs_val(Rb);
                        rem_s    = {(WIDTH+1){1'b0}};
                        sign_q_s = Ra[WIDTH-1] ^ Rb[WIDTH-1];
                        sign_r_s = Ra[WIDTH-1];
                        count_s  = {CW{1'b0}};
                        dbz_s    = 1'b0;
                        state_s  = CALC;
                    end else begin
                        // No iterations: keep the raw dividend for HI.
                        q_s     = Ra;
                        dbz_s   = 1'b1;
                        state_s = FIX;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (!trial_s[WIDTH]) begin
                    rem_s = trial_s;
                    q_s   = {q_shift_s[WIDTH-1:1], 1'b1};
                end else begin
                    rem_s = rem_shift_s;
                    q_s   = q_shift_s;
                end
                count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                if (count_r == LAST_CNT) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (dbz_r) begin
                    lo_s = ONES_W;
                    hi_s = q_r;
                end else begin
                    lo_s = sign_q_r ? neg_val(q_r) : q_r;
                    hi_s = sign_r_r ? neg_val(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
                end
                done_s    = 1'b1;
                dbz_out_s = dbz_r;
                count_s   = {CW{1'b0}};
                state_s   = IDLE;
            end
            default: begin
                state_s = IDLE;
                count_s = {CW{1'b0}};
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            q_r       <= ZERO_W;
            div_r     <= ZERO_W;
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            rem_r     <= rem_s;
            q_r       <= q_s;
            div_r     <= div_s;
            sign_q_r  <= sign_q_s;
            sign_r_r  <= sign_r_s;
            dbz_r     <= dbz_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            dbz_out_r <= dbz_out_s;
        end
    end

    assign HI          = hi_r;
    assign LO          = lo_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_out_r;

endmodule

// File: tb/tb_divide_sequential.sv
module tb_divide_sequential;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    divide_sequential #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Ra(Ra), .Rb(Rb),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: signed division truncating toward zero, remainder follows dividend.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF; r = a; z = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000; r = 32'd0; z = 1'b0;
        end else begin
            q = sa / sb; r = sa % sb; z = 1'b0;
        end
    endfunction

    // Issue one division (state assumed idle) and wait for done, bounded.
    // Returns at the cycle where done is observed (or after the bound).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cyc);
        Ra = a; Rb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        Ra = $urandom; Rb = $urandom;
        lat = 0; busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Run and fully check one operation against the model.
    task automatic check_div(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat, bc, exp_lat;
        logic [31:0] eq, er;
        logic ez;
        ref_div(a, b, eq, er, ez);
        exp_lat = (b == 32'd0) ? 1 : 33;
        run_div(a, b, lat, bc);
        n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat); end
        n_cmp++; if (bc !== exp_lat) begin n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, bc, exp_lat); end
        n_cmp++; if (LO !== eq) begin n_err++; $display("FAIL %s LO (%h/%h): got %h expected %h", tag, a, b, LO, eq); end
        n_cmp++; if (HI !== er) begin n_err++; $display("FAIL %s HI (%h/%h): got %h expected %h", tag, a, b, HI, er); end
        n_cmp++; if (div_by_zero !== ez) begin n_err++; $display("FAIL %s dbz: got %b expected %b", tag, div_by_zero, ez); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %b expected 0", tag, busy); end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; Ra = 32'd0; Rb = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({HI, LO} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h %h expected 0 0", HI, LO); end
        n_cmp++; if ({busy, done, div_by_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        check_div("d_100_7", 32'd100, 32'd7);
        n_cmp++; if ({LO, HI} !== {32'd14, 32'd2}) begin n_err++; $display("FAIL d_100_7_const: got %h %h expected 0000000e 00000002", LO, HI); end
        check_div("d_m100_7", 32'hFFFFFF9C, 32'd7);
        n_cmp++; if ({LO, HI} !== {32'hFFFFFFF2, 32'hFFFFFFFE}) begin n_err++; $display("FAIL d_m100_7_const: got %h %h expected fffffff2 fffffffe", LO, HI); end
        check_div("d_100_m7", 32'd100, 32'hFFFFFFF9);
        check_div("d_ovf", 32'h80000000, 32'hFFFFFFFF);
        check_div("d_min_1", 32'h80000000, 32'd1);
        check_div("d_m7_m7", 32'hFFFFFFF9, 32'hFFFFFFF9);
        check_div("d_3_10", 32'd3, 32'd10);
    endtask

    task automatic test_div_zero;
        logic [31:0] lo_s, hi_s;
        check_div("z_55_0", 32'd55, 32'd0);
        // done lasts exactly one cycle; HI/LO hold while idle
        lo_s = LO; hi_s = HI;
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL z_done_width: got %b expected 0", done); end
        repeat (5) begin
            Ra = $urandom; Rb = $urandom;
            @(posedge clk); #1;
        end
        n_cmp++; if ({LO, HI} !== {lo_s, hi_s}) begin n_err++; $display("FAIL z_hold: got %h %h expected %h %h", LO, HI, lo_s, hi_s); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL z_flag_hold: got %b expected 1", div_by_zero); end
        check_div("z_clear", 32'd100, 32'd7);
    endtask

    task automatic test_ignore_start;
        int lat;
        lat = 0;
        Ra = 32'd100; Rb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && lat < 40) begin
            if (lat == 10) begin start = 1'b1; Ra = 32'd9; Rb = 32'd3; end
            else start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ign_latency: got %0d expected 33", lat); end
        n_cmp++; if ({LO, HI} !== {32'd14, 32'd2}) begin n_err++; $display("FAIL ign_result: got %h %h expected 0000000e 00000002", LO, HI); end
        // start in the done cycle is accepted: back-to-back
        check_div("b2b", 32'hFFFFF000, 32'd37);
        check_div("b2b2", 32'd123456789, 32'hFFFFFF85);
    endtask

    task automatic test_abort;
        int seen;
        check_div("ab_pre", 32'd1000, 32'd3);
        Ra = 32'd100; Rb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if ({HI, LO} !== 64'd0) begin n_err++; $display("FAIL ab_hilo: got %h %h expected 0 0", HI, LO); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b expected 0", busy); end
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL ab_no_done: got %0d pulses expected 0", seen); end
        check_div("ab_post", 32'd100, 32'd7);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -($urandom_range(1, 15));
                3: begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            check_div("rnd", a, b);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_div_zero;
        test_ignore_start;
        test_abort;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
